bp_nbf_mem_arbiter: RTL and testbench

Shares a single BedRock memory command/response port between the NBF boot loader path and the core's CCE memory stream. During boot only the loader is granted. After the loader signals completion and its outstanding writes drain, the two requesters are round-robin arbitrated. Responses are steered back to the issuing requester through an in-order owner queue. The block sits between the loader/CCE side and the off-chip memory adapter in the FPGA top level.

---
 rtl/bp_nbf_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_bp_nbf_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_nbf_mem_arbiter.sv
// bp_nbf_mem_arbiter: shares one BedRock memory command/response port between the NBF loader and the core
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   nbf_cmd_*, core_cmd_*     requester command channels (valid/yumi), muxed onto mem_cmd_*
//   nbf_resp_*, core_resp_*   response channels (valid/ready), steered by an in-order owner queue
//   mem_cmd_*, mem_resp_*     shared memory port
//   nbf_done_i, boot_done_o   boot sequencing input / RUN indicator
//   error_o                   sticky flag: memory response arrived with no command outstanding
//   BP_NBF_ARB_BOOT_GATE_EN   defined: loader-only BOOT, then DRAIN, then RUN;
//                             undefined: round-robin from the first cycle after reset
module bp_nbf_mem_arbiter #(
  parameter int msg_width_p       = 576,
  parameter int max_outstanding_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [msg_width_p-1:0] nbf_cmd_i,
  input  logic                   nbf_cmd_v_i,
  output logic                   nbf_cmd_yumi_o,
  output logic [msg_width_p-1:0] nbf_resp_o,
  output logic                   nbf_resp_v_o,
  input  logic                   nbf_resp_ready_i,
  input  logic [msg_width_p-1:0] core_cmd_i,
  input  logic                   core_cmd_v_i,
  output logic                   core_cmd_yumi_o,
  output logic [msg_width_p-1:0] core_resp_o,
  output logic                   core_resp_v_o,
  input  logic                   core_resp_ready_i,
  output logic [msg_width_p-1:0] mem_cmd_o,
  output logic                   mem_cmd_v_o,
  input  logic                   mem_cmd_yumi_i,
  input  logic [msg_width_p-1:0] mem_resp_i,
  input  logic                   mem_resp_v_i,
  output logic                   mem_resp_ready_o,
  input  logic                   nbf_done_i,
  output logic                   boot_done_o,
  output logic                   error_o
);
  localparam int d  = max_outstanding_p;
  localparam int pw = $clog2(d);
  localparam int cw = $clog2(d + 1);
  localparam logic [cw-1:0] full_c = cw'(d);
  logic [cw-1:0] count_q, count_d;
  logic [pw-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [d-1:0]  own_q, own_d;
  logic          last_q, last_d, lock_q, lock_d, lock_own_q, lock_own_d;
  logic          error_q, error_d, live_q, live_d;
  logic          nbf_ok, core_ok, nv, cv, grant, push, pop, nonempty, head;
  // live_q keeps every output low while reset is held and for the cycle it releases
`ifdef BP_NBF_ARB_BOOT_GATE_EN
  typedef enum logic [1:0] {BOOT, DRAIN, RUN} state_e;
  state_e state_q, state_d;
  always_comb begin
    state_d = (state_q == BOOT && nbf_done_i) ? DRAIN :
              (state_q == DRAIN && count_q == '0 && !mem_cmd_v_o) ? RUN : state_q;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_q <= BOOT;
    else            state_q <= state_d;
  assign nbf_ok      = live_q & (state_q != DRAIN);
  assign core_ok     = live_q & (state_q == RUN);
  assign boot_done_o = state_q == RUN;
`else
  logic unused_nbf_done;
  assign unused_nbf_done = nbf_done_i;
  assign nbf_ok          = live_q;
  assign core_ok         = live_q;
  assign boot_done_o     = live_q;
`endif
  always_comb begin
    nv               = nbf_cmd_v_i & nbf_ok;
    cv               = core_cmd_v_i & core_ok;
    // a raised command stays on its requester until memory takes it
    grant            = lock_q ? lock_own_q : (nv & cv) ? ~last_q : cv;
    mem_cmd_v_o      = lock_q | ((nv | cv) & (count_q < full_c));
    mem_cmd_o        = grant ? core_cmd_i : nbf_cmd_i;
    push             = mem_cmd_v_o & mem_cmd_yumi_i;
    nbf_cmd_yumi_o   = push & ~grant;
    core_cmd_yumi_o  = push & grant;
    nonempty         = count_q != '0;
    head             = own_q[rd_q];
    nbf_resp_o       = mem_resp_i;
    core_resp_o      = mem_resp_i;
    nbf_resp_v_o     = mem_resp_v_i & nonempty & ~head;
    core_resp_v_o    = mem_resp_v_i & nonempty & head;
    mem_resp_ready_o = nonempty & (head ? core_resp_ready_i : nbf_resp_ready_i);
    pop              = mem_resp_v_i & mem_resp_ready_o;
    count_d          = count_q + cw'(push) - cw'(pop);
    wr_d             = wr_q + pw'(push);
    rd_d             = rd_q + pw'(pop);
    own_d            = push ? (own_q & ~(d'(1) << wr_q)) | (d'(grant) << wr_q) : own_q;
    last_d           = push ? grant : last_q;
    lock_d           = mem_cmd_v_o & ~mem_cmd_yumi_i;
    lock_own_d       = grant;
    error_d          = error_q | (mem_resp_v_i & ~nonempty);
    error_o          = error_q;
    live_d           = 1'b1;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      own_q      <= '0;
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
      error_q    <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      own_q      <= own_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      error_q    <= error_d;
      live_q     <= live_d;
    end
endmodule

// File: tb/tb_bp_nbf_mem_arbiter.sv
// tb_bp_nbf_mem_arbiter: randomized and directed checks of bp_nbf_mem_arbiter against a queue-level model
module tb_bp_nbf_mem_arbiter;
  localparam int W = 576, MO = 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [W-1:0] nbf_cmd = '0, core_cmd = '0, mem_resp = '0, nbf_resp, core_resp, mem_cmd;
  logic nbf_v = 0, nbf_rr = 0, core_v = 0, core_rr = 0, mem_yumi = 0, mem_rv = 0, nbf_done = 0;
  logic nbf_yumi, nbf_rv, core_yumi, core_rv, mem_v, mem_rr, boot_done, err;
  bp_nbf_mem_arbiter #(.msg_width_p(W), .max_outstanding_p(MO)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .nbf_cmd_i(nbf_cmd), .nbf_cmd_v_i(nbf_v), .nbf_cmd_yumi_o(nbf_yumi),
    .nbf_resp_o(nbf_resp), .nbf_resp_v_o(nbf_rv), .nbf_resp_ready_i(nbf_rr),
    .core_cmd_i(core_cmd), .core_cmd_v_i(core_v), .core_cmd_yumi_o(core_yumi),
    .core_resp_o(core_resp), .core_resp_v_o(core_rv), .core_resp_ready_i(core_rr),
    .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_v), .mem_cmd_yumi_i(mem_yumi),
    .mem_resp_i(mem_resp), .mem_resp_v_i(mem_rv), .mem_resp_ready_o(mem_rr),
    .nbf_done_i(nbf_done), .boot_done_o(boot_done), .error_o(err)
  );
  int tests = 0, fails = 0;
  int p_nv = 0, p_cv = 0, p_yumi = 0, p_rv = 0, p_nr = 100, p_cr = 100;
  bit bad_resp = 0;
  bit m_live, m_last, m_locked, m_lock_own, m_err, drop_n, drop_c;
  int m_phase;
  bit own[$];
  logic [W-1:0] mem_q[$], nbf_sent[$], core_sent[$];
  bit dut_grants[$];
  int n_nyumi = 0, n_cyumi = 0, n_nacc = 0;
  logic [W-1:0] lock_data;

  function automatic logic [W-1:0] rnd_msg();
    logic [W-1:0] m;
    for (int i = 0; i < W / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    own.delete(); mem_q.delete(); nbf_sent.delete(); core_sent.delete(); dut_grants.delete();
    m_live = 0; m_last = 1; m_locked = 0; m_lock_own = 0; m_err = 0; drop_n = 0; drop_c = 0;
`ifdef BP_NBF_ARB_BOOT_GATE_EN
    m_phase = 0;
`else
    m_phase = 2;
`endif
  endtask

  // one clock: drive at negedge, check 1 time unit later, advance the model for the next posedge
  task automatic cycle();
    bit nv, cv, ne, head, e_v, e_g, e_push, e_pop, e_rr, e_nrv, e_crv;
    int sz;
    @(negedge clk);
    if (drop_n) nbf_v = 0;
    if (drop_c) core_v = 0;
    drop_n = 0; drop_c = 0;
    if (!nbf_v && $urandom_range(99) < p_nv) begin nbf_v = 1; nbf_cmd = rnd_msg(); end
    if (!core_v && $urandom_range(99) < p_cv) begin core_v = 1; core_cmd = rnd_msg(); end
    nbf_rr = $urandom_range(99) < p_nr;
    core_rr = $urandom_range(99) < p_cr;
    if (mem_q.size() > 0) begin mem_rv = $urandom_range(99) < p_rv; mem_resp = mem_q[0]; end
    else begin mem_rv = bad_resp; mem_resp = rnd_msg(); end
    sz = own.size();
    nv = nbf_v & m_live & (m_phase != 1);
    cv = core_v & m_live & (m_phase == 2);
    e_v = m_locked | ((nv | cv) & (sz < MO));
    e_g = m_locked ? m_lock_own : (nv & cv) ? !m_last : cv;
    mem_yumi = e_v && ($urandom_range(99) < p_yumi);
    e_push = e_v & mem_yumi;
    ne = sz > 0;
    head = ne ? own[0] : 1'b0;
    e_rr = ne & (head ? core_rr : nbf_rr);
    e_nrv = mem_rv & ne & !head;
    e_crv = mem_rv & ne & head;
    e_pop = mem_rv & e_rr;
    #1;
    chk("mem_cmd_v", mem_v, e_v);
    if (e_v) chk("mem_cmd", mem_cmd, e_g ? core_cmd : nbf_cmd);
    chk("nbf_yumi", nbf_yumi, e_push & !e_g);
    chk("core_yumi", core_yumi, e_push & e_g);
    chk("mem_resp_ready", mem_rr, e_rr);
    chk("nbf_resp_v", nbf_rv, e_nrv);
    chk("core_resp_v", core_rv, e_crv);
    if (e_nrv) chk("nbf_resp", nbf_resp, nbf_sent[0]);
    if (e_crv) chk("core_resp", core_resp, core_sent[0]);
    chk("boot_done", boot_done, m_live && m_phase == 2);
    chk("error", err, m_err);
    if (nbf_yumi) begin dut_grants.push_back(0); n_nyumi++; end
    if (core_yumi) begin dut_grants.push_back(1); n_cyumi++; end
    if (nbf_rv & nbf_rr) n_nacc++;
`ifdef BP_NBF_ARB_BOOT_GATE_EN
    if (m_phase == 0 && nbf_done) m_phase = 1;
    else if (m_phase == 1 && sz == 0 && !e_v) m_phase = 2;
`endif
    if (e_pop) begin
      own.pop_front(); mem_q.pop_front();
      if (head) core_sent.pop_front(); else nbf_sent.pop_front();
    end
    if (e_push) begin
      own.push_back(e_g); m_last = e_g;
      if (e_g) begin core_sent.push_back(core_cmd); mem_q.push_back(core_cmd); drop_c = 1; end
      else begin nbf_sent.push_back(nbf_cmd); mem_q.push_back(nbf_cmd); drop_n = 1; end
    end
    m_err = m_err | (mem_rv & !ne);
    m_locked = e_v & !mem_yumi;
    m_lock_own = e_g;
    m_live = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 0; nbf_v = 1; core_v = 1; mem_rv = 1; mem_yumi = 1; nbf_rr = 1; core_rr = 1;
    #1;
    chk("rst_mem_cmd_v", mem_v, 0);
    chk("rst_nbf_yumi", nbf_yumi, 0);
    chk("rst_core_yumi", core_yumi, 0);
    chk("rst_nbf_resp_v", nbf_rv, 0);
    chk("rst_core_resp_v", core_rv, 0);
    chk("rst_mem_resp_ready", mem_rr, 0);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_error", err, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    nbf_v = 0; core_v = 0; mem_rv = 0; mem_yumi = 0; nbf_done = 0;
    rst_n = 1;
  endtask

  task automatic idle();
    int n = 0;
    p_nv = 0; p_cv = 0; p_yumi = 100; p_rv = 100; p_nr = 100; p_cr = 100; bad_resp = 0;
    while ((nbf_v || core_v || own.size() > 0 || m_locked) && n < 300) begin cycle(); n++; end
    tests++;
    if (n >= 300) begin fails++; $display("FAIL idle_timeout: busy after %0d cycles, expected idle", n); end
  endtask

`ifdef BP_NBF_ARB_BOOT_GATE_EN
  task automatic go_run();
    int n = 0;
    p_nv = 0; p_cv = 0; nbf_done = 1;
    while (m_phase != 2 && n < 20) begin cycle(); n++; end
    tests++;
    if (n >= 20) begin fails++; $display("FAIL go_run_timeout: no RUN after %0d cycles", n); end
  endtask

  task automatic boot_test();
    int n = 0;
    p_nv = 100; p_cv = 100; p_yumi = 100; p_rv = 0; p_nr = 100; p_cr = 100;
    n_nyumi = 0; n_cyumi = 0;
    while (n_nyumi < 3 && n < 50) begin cycle(); n++; end
    nbf_done = 1; p_nv = 0;
    repeat (10) cycle();
    chk("boot_nbf_yumis", n_nyumi, 3);
    chk("boot_core_yumis", n_cyumi, 0);
    chk("boot_done_low", boot_done, 0);
    p_rv = 100; n = 0;
    while (!boot_done && n < 50) begin cycle(); n++; end
    chk("drain_to_run", boot_done, 1);
  endtask
`endif

  initial begin
    m_reset();
    do_reset();
`ifdef BP_NBF_ARB_BOOT_GATE_EN
    boot_test();
    do_reset();
    go_run();
`else
    chk("boot_done_at_release", boot_done, 0);
`endif
    p_nv = 100; p_cv = 100; p_yumi = 100; p_rv = 0; p_nr = 100; p_cr = 100;
    repeat (8) cycle();
    chk("rr_issue_count", dut_grants.size(), 4);
    chk("rr_grant0_nbf", dut_grants[0], 0);
    chk("rr_grant1_core", dut_grants[1], 1);
    chk("rr_grant2_nbf", dut_grants[2], 0);
    chk("rr_grant3_core", dut_grants[3], 1);
    chk("full_cmd_v_low", mem_v, 0);
    chk("boot_done_run", boot_done, 1);
    nbf_v = 0; core_v = 0; p_nv = 0; p_cv = 0; p_rv = 100; p_nr = 100; p_cr = 0; n_nacc = 0;
    repeat (3) cycle();
    chk("head_core_blocks_ready", mem_rr, 0);
    chk("head_core_resp_v", core_rv, 1);
    chk("later_nbf_blocked", nbf_rv, 0);
    chk("nbf_resp_count", n_nacc, 1);
    idle();
    nbf_v = 1; nbf_cmd = rnd_msg();
    idle();
    lock_data = rnd_msg();
    nbf_v = 1; nbf_cmd = lock_data; p_yumi = 0;
    cycle();
    core_v = 1; core_cmd = rnd_msg(); n_cyumi = 0;
    repeat (5) begin cycle(); chk("lock_cmd_held", mem_cmd, lock_data); end
    chk("lock_no_core_yumi", n_cyumi, 0);
    p_yumi = 100; n_nyumi = 0;
    cycle();
    chk("lock_release_nbf_yumi", n_nyumi, 1);
    idle();
    bad_resp = 1;
    cycle();
    chk("orphan_nbf_resp_v", nbf_rv, 0);
    chk("orphan_core_resp_v", core_rv, 0);
    chk("orphan_mem_resp_ready", mem_rr, 0);
    bad_resp = 0;
    repeat (2) cycle();
    chk("error_sticky", err, 1);
    nbf_v = 1; nbf_cmd = rnd_msg(); p_yumi = 0;
    cycle();
    do_reset();
`ifdef BP_NBF_ARB_BOOT_GATE_EN
    go_run();
`endif
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        p_nv = $urandom_range(100); p_cv = $urandom_range(100); p_yumi = $urandom_range(100);
        p_rv = $urandom_range(100); p_nr = $urandom_range(100); p_cr = $urandom_range(100);
      end
      cycle();
    end
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
